// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Byte buffer and launch controller sitting in front of the UART transmit FSM.
// Host writes land in a circular FIFO; the launcher pops one byte at a time,
// presents it on P_DATA with a one-cycle Data_valid strobe, then holds P_DATA
// until the transmitter's busy line has risen and fallen again.
//
// Optional feature macro: UART_TX_FIFO_OVF_EN
//   defined   -> adds sticky overflow flag ovf (set on a dropped write) and its
//                clear input ovf_clr; a set in the same cycle as a clear wins.
//   undefined -> writes while full are silently discarded, no extra ports.
//
// Parameters
//   DATA_WIDTH  byte width presented to the serializer
//   DEPTH       FIFO entries, power of two, >= 2
//
// Ports
//   clk         rising-edge clock, shared with the TX FSM
//   rst         synchronous active-high reset
//   wr_en       write strobe, one byte per asserted cycle
//   wr_data     byte to enqueue
//   full        FIFO holds DEPTH entries (registered)
//   empty       FIFO holds no entries (registered)
//   count       current occupancy (registered)
//   tx_busy     busy indication from the TX FSM
//   P_DATA      byte being transmitted (registered)
//   Data_valid  one-cycle launch strobe to the TX FSM (registered)
//   ovf         sticky overflow flag            (macro builds only)
//   ovf_clr     clears ovf                      (macro builds only)
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    input  logic                    tx_busy,
    output logic [DATA_WIDTH-1:0]   P_DATA,
    output logic                    Data_valid
`ifdef UART_TX_FIFO_OVF_EN
    ,
    output logic                    ovf,
    input  logic                    ovf_clr
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t                 state_reg, state_next;
    logic [PTR_W-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]       count_reg, count_next;
    logic                   full_reg, empty_reg;
    logic [DATA_WIDTH-1:0]  p_data_reg;
    logic                   data_valid_reg;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    logic push, pop;

    // full is taken from the registered state, so a write while full is
    // dropped even when the launcher pops in the same cycle.
    assign push = wr_en && !full_reg;

    // -------------------------------------------------------------------------
    // Launch FSM: next state and pop decision
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (!empty_reg && !tx_busy) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            // busy is ignored here: the TX FSM only reacts to the strobe
            // on the following edge.
            ISSUE:     state_next = WAIT_BUSY;
            WAIT_BUSY: if (tx_busy)  state_next = WAIT_DONE;
            WAIT_DONE: if (!tx_busy) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Occupancy bookkeeping
    // -------------------------------------------------------------------------
    always_comb begin
        count_next = count_reg;
        unique case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            // Pointers are exactly PTR_W bits, so DEPTH-1 + 1 wraps to 0.
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
            full_reg  <= (count_next == CNT_W'(DEPTH));
            empty_reg <= (count_next == '0);
        end
    end

    // -------------------------------------------------------------------------
    // Storage: no reset, so it maps onto block/distributed RAM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // -------------------------------------------------------------------------
    // Launch outputs: P_DATA is the registered RAM read, loaded only on a pop,
    // and the strobe is high in exactly the cycle the FSM sits in ISSUE.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            p_data_reg     <= '0;
            data_valid_reg <= 1'b0;
        end else begin
            if (pop) p_data_reg <= mem[rd_ptr_reg];
            data_valid_reg <= pop;
        end
    end

    assign full       = full_reg;
    assign empty      = empty_reg;
    assign count      = count_reg;
    assign P_DATA     = p_data_reg;
    assign Data_valid = data_valid_reg;

`ifdef UART_TX_FIFO_OVF_EN
    // -------------------------------------------------------------------------
    // Sticky overflow flag; a dropped write takes priority over the clear.
    // -------------------------------------------------------------------------
    logic ovf_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (wr_en && full_reg) begin
            ovf_reg <= 1'b1;
        end else if (ovf_clr) begin
            ovf_reg <= 1'b0;
        end
    end

    assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Self-checking bench for uart_tx_fifo. A queue-based reference model tracks
// the bytes held, the byte on the output and the frame handshake with the
// transmitter; every cycle the DUT outputs are compared against it. Directed
// scenarios cover latency, burst/overflow, simultaneous push/pop, a stuck
// transmitter and reset mid-frame, followed by a randomized phase.
// Build with UART_TX_FIFO_OVF_EN defined to also cover the overflow flag.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          tx_busy = 1'b0;
    logic          full, empty, Data_valid;
    logic [3:0]    count;
    logic [DW-1:0] P_DATA;
`ifdef UART_TX_FIFO_OVF_EN
    logic          ovf;
    logic          ovf_clr = 1'b0;
`endif

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .tx_busy    (tx_busy),
        .P_DATA     (P_DATA),
        .Data_valid (Data_valid)
`ifdef UART_TX_FIFO_OVF_EN
        ,
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
`endif
    );

    // ---------------------------------------------------------------- model
    logic [DW-1:0] m_q [$];
    logic [DW-1:0] m_pdata     = '0;
    bit            m_dv        = 1'b0;
    bit            m_frame_open = 1'b0;  // a byte was launched, handshake not finished
    bit            m_busy_seen = 1'b0;   // transmitter has acknowledged the launch
    bit            m_ovf       = 1'b0;

    // transmitter stand-in: 0 = reacts to strobes, 1 = stuck high, 2 = stuck low
    int            tx_mode = 0;
    int            tx_len  = 0;          // busy length per frame, 0 = random 1..6
    int            busy_cnt = 0;

    logic [DW-1:0] launched [$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Advance the reference by one clock edge using the inputs applied now.
    task automatic model_update();
        int n;
        bit do_push, do_pop, strobe_cycle;
        if (rst) begin
            m_q.delete();
            m_pdata      = '0;
            m_dv         = 1'b0;
            m_frame_open = 1'b0;
            m_busy_seen  = 1'b0;
            m_ovf        = 1'b0;
        end else begin
            n            = m_q.size();
            strobe_cycle = m_dv;
            do_push      = wr_en && (n < DEPTH);
            do_pop       = !m_frame_open && (n > 0) && !tx_busy;
`ifdef UART_TX_FIFO_OVF_EN
            if (wr_en && n == DEPTH) m_ovf = 1'b1;
            else if (ovf_clr)        m_ovf = 1'b0;
`endif
            // The strobe cycle itself never counts as an acknowledgement.
            if (m_frame_open && !strobe_cycle) begin
                if (!m_busy_seen) begin
                    if (tx_busy) m_busy_seen = 1'b1;
                end else if (!tx_busy) begin
                    m_frame_open = 1'b0;
                end
            end
            if (do_pop) begin
                m_pdata      = m_q.pop_front();
                m_frame_open = 1'b1;
                m_busy_seen  = 1'b0;
            end
            if (do_push) m_q.push_back(wr_data);
            m_dv = do_pop;
        end
    endtask

    task automatic compare_outputs();
        check("count", 32'(count), 32'(m_q.size()));
        check("full",  32'(full),  32'(m_q.size() == DEPTH));
        check("empty", 32'(empty), 32'(m_q.size() == 0));
        check("dv",    32'(Data_valid), 32'(m_dv));
        check("pdata", 32'(P_DATA), 32'(m_pdata));
`ifdef UART_TX_FIFO_OVF_EN
        check("ovf",   32'(ovf), 32'(m_ovf));
`endif
    endtask

    task automatic tx_model();
        if (rst) busy_cnt = 0;
        case (tx_mode)
            1:       tx_busy = 1'b1;
            2:       tx_busy = 1'b0;
            default: begin
                if (busy_cnt > 0) begin
                    tx_busy = 1'b1;
                    busy_cnt--;
                end else begin
                    tx_busy = 1'b0;
                end
                if (m_dv) busy_cnt = (tx_len == 0) ? int'($urandom_range(1, 6)) : tx_len;
            end
        endcase
    endtask

    // One clock: DUT and model take the edge, outputs checked mid-cycle.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        cyc++;
        compare_outputs();
        if (Data_valid === 1'b1) begin
            launched.push_back(P_DATA);
            $display("cycle %0d: launch byte %02h, count %0d", cyc, P_DATA, count);
        end
        tx_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write_byte(input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        // Reset state
        rst = 1'b1;
        idle(2);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full",  32'(full),  32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_pdata", 32'(P_DATA), 32'd0);
        rst = 1'b0;
        idle(2);

        // Single byte: strobe two cycles after the write, byte held while busy
        tx_mode = 0;
        tx_len  = 10;
        write_byte(8'hA5);
        check("a5_count_n1", 32'(count), 32'd1);
        check("a5_dv_n1",    32'(Data_valid), 32'd0);
        step();
        check("a5_dv_n2",    32'(Data_valid), 32'd1);
        check("a5_pdata_n2", 32'(P_DATA), 32'hA5);
        for (int i = 0; i < 11; i++) begin
            step();
            check("a5_hold", 32'(P_DATA), 32'hA5);
            check("a5_empty", 32'(empty), 32'd1);
        end
        idle(4);

        // Burst while the transmitter is busy: fill, drop the ninth, drain in order
        tx_mode = 1;
        tx_busy = 1'b1;
        for (int i = 1; i <= 8; i++) write_byte(DW'(i));
        check("burst_full",  32'(full),  32'd1);
        check("burst_count", 32'(count), 32'd8);
        write_byte(8'h09);
        check("burst_drop_count", 32'(count), 32'd8);
`ifdef UART_TX_FIFO_OVF_EN
        check("burst_ovf", 32'(ovf), 32'd1);
`endif
        launched.delete();
        tx_mode = 0;
        tx_len  = 3;
        idle(80);
        check("burst_nlaunch", 32'(launched.size()), 32'd8);
        for (int i = 0; i < 8 && i < launched.size(); i++)
            check("burst_order", 32'(launched[i]), 32'(i + 1));

        // Push coinciding with a pop keeps count, then pointer wrap traffic
        tx_mode = 1;
        tx_busy = 1'b1;
        for (int i = 0; i < 3; i++) write_byte(DW'(8'h10 + i));
        check("pp_count3", 32'(count), 32'd3);
        tx_mode = 0;
        tx_len  = 1;
        tx_busy = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'h13;
        step();
        wr_en   = 1'b0;
        check("pp_count_same", 32'(count), 32'd3);
        check("pp_dv", 32'(Data_valid), 32'd1);
        check("pp_pdata", 32'(P_DATA), 32'h10);
        for (int i = 0; i < 20; i++) begin
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_data = DW'($urandom);
            step();
        end
        wr_en = 1'b0;
        idle(40);

        // Transmitter never raises busy: stays waiting, no second strobe
        tx_mode = 2;
        tx_busy = 1'b0;
        launched.delete();
        write_byte(8'h5A);
        write_byte(8'h6B);
        write_byte(8'h7C);
        idle(30);
        check("stuck_nlaunch", 32'(launched.size()), 32'd1);
        check("stuck_pdata", 32'(P_DATA), 32'h5A);
        check("stuck_count", 32'(count), 32'd2);

        // Reset while waiting for busy to fall with four bytes queued
        do_reset();
        tx_mode = 0;
        tx_len  = 40;
        for (int i = 0; i < 5; i++) write_byte(DW'(8'h20 + i));
        idle(6);
        check("rstmid_count4", 32'(count), 32'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstmid_count", 32'(count), 32'd0);
        check("rstmid_empty", 32'(empty), 32'd1);
        check("rstmid_dv",    32'(Data_valid), 32'd0);
        check("rstmid_pdata", 32'(P_DATA), 32'd0);
`ifdef UART_TX_FIFO_OVF_EN
        check("rstmid_ovf",   32'(ovf), 32'd0);

        // Overflow flag: set beats clear, then clear alone
        tx_mode = 1;
        tx_busy = 1'b1;
        idle(2);
        for (int i = 0; i < 9; i++) write_byte(DW'(8'h40 + i));
        check("ovf_set", 32'(ovf), 32'd1);
        wr_en   = 1'b1;
        ovf_clr = 1'b1;
        step();
        wr_en   = 1'b0;
        check("ovf_set_wins", 32'(ovf), 32'd1);
        step();
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(ovf), 32'd0);
        do_reset();
`else
        do_reset();
`endif

        // Randomized traffic with random busy lengths and occasional resets
        tx_mode = 0;
        tx_len  = 0;
        for (int i = 0; i < 400; i++) begin
            wr_en   = ($urandom_range(0, 99) < 45);
            wr_data = DW'($urandom);
            rst     = ($urandom_range(0, 199) == 0);
`ifdef UART_TX_FIFO_OVF_EN
            ovf_clr = ($urandom_range(0, 19) == 0);
`endif
            step();
        end
        wr_en = 1'b0;
        rst   = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
        ovf_clr = 1'b0;
`endif
        idle(100);
        check("final_empty", 32'(empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
